branch_resolve_bht: RTL
=======================

# branch_resolve_bht

Branch prediction and resolution unit for the RISC-V pipeline. It supplies a direction/target prediction to the fetch stage from a direct-mapped branch history table (BHT) with per-entry target. It consumes the `cmp` result of the EX-stage branch compare, detects mispredictions, and issues a registered flush/redirect to fetch. It updates the table's 2-bit saturating counters and keeps branch and mispredict statistics counters.

## Interface
Parameters:
- `ENTRIES`, 64: number of BHT entries; power of two.
- `IDX_W`, 6: index width, log2(ENTRIES).

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `if_pc`, input, 32: fetch PC to predict.
- `pred_taken`, output, 1: combinational prediction for `if_pc`.
- `pred_target`, output, 32: combinational predicted target for `if_pc`.
- `ex_valid`, input, 1: EX holds a branch/jump to resolve this cycle.
- `ex_stall`, input, 1: EX frozen; suppresses resolution.
- `ex_opcode`, input, 5: instr[6:2]; 11000 is branch, 11011 is JAL, 11001 is JALR.
- `ex_pc`, input, 32: PC of the resolving instruction.
- `ex_target`, input, 32: computed taken target.
- `ex_pred_taken`, input, 1: prediction carried down the pipe with the instruction.
- `ex_pred_target`, input, 32: predicted target carried down the pipe.
- `cmp`, input, 1: actual taken; the compare unit drives 1 for JAL/JALR.
- `flush`, output, 1: registered; kill IF/ID/EX younger instructions.
- `redirect_pc`, output, 32: registered; fetch restart address, valid while `flush` = 1.
- `br_count`, output, 32: resolved branch/jump count.
- `mispredict_count`, output, 32: misprediction count.

## Operation
- Index: `idx = pc[IDX_W+1:2]`. No tags; aliasing is permitted.
- Entry contents: `valid`, `ctr[1:0]`, `target[31:0]`.
- Lookup:
  - `pred_taken = valid[idx] & ctr[idx][1]`.
  - `pred_target = target[idx]`; 0 when `valid` = 0.
- Resolve event: `res = ex_valid & ~ex_stall & ~flush`. A resolve while `flush` = 1 is wrong-path and is ignored entirely: no update, no count.
- Mispredict, `mis`:
  - `cmp != ex_pred_taken`, or
  - `cmp & ex_pred_taken & (ex_target != ex_pred_target)`.
- Redirect target: `cmp ? ex_target : ex_pc + 4`, 32-bit wrap.
- Table update on `res`, branch (opcode 11000):
  - `ctr` saturating: +1 if `cmp`, capped at 11; -1 if not `cmp`, floored at 00.
  - If `cmp`: set `valid` and write `target`.
  - If not `cmp` and `valid` = 0: `ctr` still updates and `valid` stays 0.
- Table update on `res`, JAL/JALR: `ctr` = 11, `valid` = 1, `target` = `ex_target`.
- Other opcodes with `res`: no table update, no count, no flush.
- Counters:
  - `br_count` += 1 on each branch/jump `res`.
  - `mispredict_count` += 1 when `mis` also holds.
  - Both wrap at 2^32.
- Reset (`rst_n` = 0 at an edge):
  - Every entry: `valid` = 0, `ctr` = 01 (weakly not-taken), `target` = 0.
  - `flush` = 0, `redirect_pc` = 0, `br_count` = 0, `mispredict_count` = 0.
  - Reset dominates any simultaneous resolve.

## Timing
- Lookup is zero-latency: outputs follow `if_pc` combinationally from the table state.
- Resolve at edge N (`res` sampled before edge N):
  - Table and counters are updated at edge N.
  - On `mis`, `flush` = 1 and `redirect_pc` are driven for exactly the cycle after edge N; `flush` drops at edge N+1.
  - Without `mis`, `flush` = 0.
- Same-index lookup and update in one cycle: lookup returns the pre-update value (read-before-write).
- Back-to-back resolves: each cycle is processed independently, except the cycle where `flush` = 1, which is ignored as above.
- Reset mid-flush: `flush` = 0 on the cycle after the reset edge. The table returns to its reset contents in one cycle.

## Test plan
- Reset, then lookup `if_pc` = 0x100 → `pred_taken` = 0, `pred_target` = 0. Both counters read 0.
- Branch at `ex_pc` = 0x100, `ex_target` = 0x140, `cmp` = 1, `ex_pred_taken` = 0 → next cycle `flush` = 1, `redirect_pc` = 0x140. Then `ctr` = 10, lookup 0x100 gives `pred_taken` = 1, `pred_target` = 0x140, `mispredict_count` = 1.
- Same branch resolved not-taken 3 times with correct predictions fed → `ctr` saturates at 00 and `flush` toggles only on real mispredicts. Not-taken redirect = 0x104.
- JALR at 0x200, `ex_pred_taken` = 1, `ex_pred_target` = 0x300, `ex_target` = 0x380 → `flush` = 1, `redirect_pc` = 0x380. Entry becomes ctr 11 with target 0x380.
- Mispredict followed next cycle by `ex_valid` = 1 during `flush` → second event ignored: `br_count` increments once, no table change.
- Resolve with `ex_stall` = 1 → no update and no flush. Assert `rst_n` = 0 on the cycle `flush` = 1 → all outputs 0 next cycle and lookup of 0x100 gives `pred_taken` = 0.

Source files
------------

// File: rtl/branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// branch_resolve_bht
//
// Branch prediction and resolution unit. A direct-mapped, untagged branch
// history table (valid bit, 2-bit saturating counter and a target per entry)
// gives fetch a combinational direction/target prediction. The EX-stage
// branch/jump outcome is compared against the prediction that travelled down
// the pipe. A mismatch produces a one-cycle registered flush plus a restart
// address for fetch. The table is trained on every resolved branch or jump, and
// branch and mispredict statistics are kept.
//
// Ports
//   clk_i               clock; all state changes on the rising edge
//   rst_ni              synchronous active-low reset
//   if_pc_i             fetch PC to look up
//   pred_taken_o        predicted direction for if_pc_i (combinational)
//   pred_target_o       predicted target for if_pc_i (combinational)
//   ex_valid_i          EX holds a branch/jump to resolve
//   ex_stall_i          EX frozen; no resolution this cycle
//   ex_opcode_i         instr[6:2] of the resolving instruction
//   ex_pc_i             PC of the resolving instruction
//   ex_target_i         computed taken target
//   ex_pred_taken_i     prediction carried with the instruction
//   ex_pred_target_i    predicted target carried with the instruction
//   cmp_i               actual taken (1 for JAL/JALR)
//   flush_o             registered kill of younger IF/ID/EX instructions
//   redirect_pc_o       registered fetch restart address, valid with flush_o
//   br_count_o          resolved branch/jump count
//   mispredict_count_o  misprediction count
// -----------------------------------------------------------------------------
module branch_resolve_bht #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] if_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic        ex_stall_i,
  input  logic [4:0]  ex_opcode_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  input  logic        cmp_i,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] br_count_o,
  output logic [31:0] mispredict_count_o
);

  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpJalr   = 5'b11001;

  // Table storage
  logic              valid_q  [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];

  logic              flush_q;
  logic [31:0]       redirectPc_q;
  logic [31:0]       brCount_q;
  logic [31:0]       mispredictCount_q;

  // Next-state values
  logic              flush_d;
  logic [31:0]       redirectPc_d;
  logic [31:0]       brCount_d;
  logic [31:0]       mispredictCount_d;
  logic              entryValid_d;
  logic [1:0]        entryCtr_d;
  logic [31:0]       entryTarget_d;

  logic [IDX_W-1:0]  ifIdx;
  logic [IDX_W-1:0]  exIdx;
  logic              isBranch;
  logic              isJump;
  logic              resolve;
  logic              mispredict;

  assign ifIdx = if_pc_i[IDX_W+1:2];
  assign exIdx = ex_pc_i[IDX_W+1:2];

  // Lookup reads the registered table, so a same-cycle update at the same
  // index is not visible until the next cycle.
  always_comb begin
    pred_taken_o  = valid_q[ifIdx] & ctr_q[ifIdx][1];
    pred_target_o = valid_q[ifIdx] ? target_q[ifIdx] : 32'd0;
  end

  assign isBranch = (ex_opcode_i == OpBranch);
  assign isJump   = (ex_opcode_i == OpJal) || (ex_opcode_i == OpJalr);

  // Anything resolving while flush is high is on the wrong path and is
  // dropped; non-control opcodes never count as a resolve.
  assign resolve = ex_valid_i & ~ex_stall_i & ~flush_q & (isBranch | isJump);

  assign mispredict = (cmp_i != ex_pred_taken_i) |
                      (cmp_i & ex_pred_taken_i & (ex_target_i != ex_pred_target_i));

  always_comb begin
    flush_d           = resolve & mispredict;
    redirectPc_d      = redirectPc_q;
    brCount_d         = brCount_q;
    mispredictCount_d = mispredictCount_q;
    entryValid_d      = valid_q[exIdx];
    entryCtr_d        = ctr_q[exIdx];
    entryTarget_d     = target_q[exIdx];

    if (resolve) begin
      brCount_d = brCount_q + 32'd1;
      if (mispredict) begin
        mispredictCount_d = mispredictCount_q + 32'd1;
        redirectPc_d      = cmp_i ? ex_target_i : ex_pc_i + 32'd4;
      end
      if (isJump) begin
        entryValid_d  = 1'b1;
        entryCtr_d    = 2'b11;
        entryTarget_d = ex_target_i;
      end else if (cmp_i) begin
        entryValid_d  = 1'b1;
        entryTarget_d = ex_target_i;
        if (ctr_q[exIdx] != 2'b11) entryCtr_d = ctr_q[exIdx] + 2'd1;
      end else begin
        // Not-taken training still moves the counter on an invalid entry,
        // but never makes that entry valid.
        if (ctr_q[exIdx] != 2'b00) entryCtr_d = ctr_q[exIdx] - 2'd1;
      end
    end
  end

  // Reset restores every entry to weakly not-taken with no target.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= 2'b01;
        target_q[i] <= 32'd0;
      end
      flush_q           <= 1'b0;
      redirectPc_q      <= 32'd0;
      brCount_q         <= 32'd0;
      mispredictCount_q <= 32'd0;
    end else begin
      if (resolve) begin
        valid_q[exIdx]  <= entryValid_d;
        ctr_q[exIdx]    <= entryCtr_d;
        target_q[exIdx] <= entryTarget_d;
      end
      flush_q           <= flush_d;
      redirectPc_q      <= redirectPc_d;
      brCount_q         <= brCount_d;
      mispredictCount_q <= mispredictCount_d;
    end
  end

  assign flush_o            = flush_q;
  assign redirect_pc_o      = redirectPc_q;
  assign br_count_o         = brCount_q;
  assign mispredict_count_o = mispredictCount_q;

endmodule
